load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: WORD_IDX_W, default 6, width of word index driven on Address (64-word data memory).
REQ-002 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: req_valid  input  1  pipeline request present; req_ready  output  1  unit can accept.
REQ-005 SHALL have ports: req_we  input  1  1=store, 0=load; req_size  input  2  00 byte, 01 half, 10/11 word; req_unsigned  input  1  zero-extend sub-word loads.
REQ-006 SHALL have ports: req_addr  input  32  byte address; req_wdata  input  32  store data, right-aligned.
REQ-007 SHALL have ports: resp_valid  output  1  one-cycle completion pulse; resp_rdata  output  32  load result; resp_err  output  1  access rejected.
REQ-008 SHALL have ports: MemRead  output  1; MemWrite  output  1; Address  output  32  word index; write_data  output  32; Read_Data  input  32  combinational read data of the data memory.

Function
REQ-009 SHALL implement Moore FSM states IDLE, READ, WRITE, RESP; memory-side outputs decoded from registered state/request only.
REQ-010 SHALL assert req_ready only in IDLE; request accepted on edge where req_valid && req_ready; addr/size/we/unsigned/wdata captured then.
REQ-011 SHALL drive Address = {zeros, captured addr[WORD_IDX_W+1:2]}; upper address bits ignored (word index wraps modulo 2^WORD_IDX_W).
REQ-012 SHALL on load: IDLE->READ->RESP; MemRead=1 only in READ; Read_Data captured at end of READ.
REQ-013 SHALL on word store: IDLE->WRITE->RESP; MemWrite=1 only in WRITE, write_data=captured wdata.
REQ-014 SHALL on byte/half store (read-modify-write): IDLE->READ->WRITE->RESP; write_data = captured old word with addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
REQ-015 SHALL use little-endian lanes: byte lane = addr[1:0], half lane = addr[1]; load result = lane data sign-extended, or zero-extended if req_unsigned.
REQ-016 SHALL pulse resp_valid for exactly one cycle in RESP, then return to IDLE; resp_rdata valid with it (0 for stores); latency accept-edge to resp_valid: load 2, word store 2, sub-word store 3 cycles.
REQ-017 SHALL never assert MemRead and MemWrite in the same cycle; both 0 in IDLE and RESP.
REQ-018 SHALL ignore req_valid outside IDLE (no queueing); back-to-back requests accepted on the cycle after RESP.
REQ-019 SHALL hold resp_rdata and resp_err stable until next RESP.

Reset
REQ-020 SHALL on rst=1 immediately (asynchronously) enter IDLE and clear req_ready, resp_valid, resp_rdata, resp_err, MemRead, MemWrite, Address, write_data, captured request.
REQ-021 SHALL abort any in-flight access on reset without completing MemWrite or issuing resp_valid; req_ready returns 1 the first cycle after rst deasserts.

Configuration
REQ-022 SHALL honour macro MISALIGN_CHECK_EN: when defined, half with addr[0]=1 or word with addr[1:0]!=0 performs no memory access, goes IDLE->RESP with resp_valid next cycle, resp_err=1, resp_rdata=0.
REQ-023 SHALL without MISALIGN_CHECK_EN: resp_err tied 0; half ignores addr[0], word ignores addr[1:0]; no misaligned path.

Verification
REQ-024 SHALL cover: reset, word store addr 0x10 data 0xDEADBEEF -> MemWrite one cycle, Address=4, write_data=0xDEADBEEF, resp_valid 2 cycles after accept.
REQ-025 SHALL cover: word load addr 0x10 after REQ-024 -> MemRead one cycle, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-026 SHALL cover: byte store 0x55 at 0x12 over 0xDEADBEEF -> READ then WRITE, write_data=0xDE55BEEF, resp_valid 3 cycles after accept; signed byte load 0x13 -> 0xFFFFFFDE, unsigned -> 0x000000DE.
REQ-027 SHALL cover: half load 0x12 signed from 0xDE55BEEF -> 0xFFFFDE55; addr 0x100 word load -> Address=0 (wrap).
REQ-028 SHALL cover: rst asserted during WRITE of sub-word store -> MemWrite drops immediately, no resp_valid, memory word unchanged.
REQ-029 SHALL cover: word load at 0x11 -> with MISALIGN_CHECK_EN resp_err=1, no MemRead, resp_valid 1 cycle after accept; without, reads word index 4, resp_err=0.

Source files
------------

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Bundles every non-clock signal of the load/store unit.
// The signals fall into three groups:
//   - Pipeline request side:
//       req_valid, req_ready, req_we, req_size, req_unsigned,
//       req_addr, req_wdata
//   - Pipeline response side:
//       resp_valid, resp_rdata, resp_err
//   - Data memory side:
//       MemRead, MemWrite, Address, write_data, Read_Data
// The unit itself connects through the slave modport. The pipeline/memory
// environment (or a testbench) connects through the master modport.
// ---------------------------------------------------------------------------
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] write_data;
    logic [31:0] Read_Data;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  Read_Data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output MemRead, MemWrite, Address, write_data
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output Read_Data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  MemRead, MemWrite, Address, write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Accepts one load or store at a time from the pipeline and carries it out
// against a word-addressed data memory whose read data is combinational.
// Sub-word stores are done as read-modify-write. Memory lanes are
// little-endian.
//
// Ports:
//   clk  - single clock; all state changes on the rising edge
//   rst  - asynchronous, active-high reset; aborts any access in flight
//   bus  - load_store_unit_if.slave, which carries:
//            the request handshake (req_*)
//            the one-cycle response (resp_*)
//            the memory side (MemRead/MemWrite/Address/write_data/Read_Data)
//
// Parameter:
//   WORD_IDX_W - width of the word index driven on Address
//                (default 6, i.e. a 64-word memory)
//
// Build option:
//   MISALIGN_CHECK_EN - when defined, a misaligned half or word access is
//                       rejected with resp_err and never touches memory.
//                       When undefined, resp_err is tied low and the
//                       low address bits are simply ignored.
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int WORD_IDX_W = 6
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [1:0]              size_q, size_d;
    logic                    zext_q, zext_d;
    logic [WORD_IDX_W+1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             oldWord_q, oldWord_d;
    logic [31:0]             respRdata_q, respRdata_d;
    logic                    accept;
    logic                    misaligned;
    logic                    unusedAddrHi;

    // Only the word-index and lane bits of the address are kept.
    // Everything above them wraps away.
    assign unusedAddrHi = ^bus.req_addr[31:WORD_IDX_W+2];

    // Pick the addressed lane out of a memory word. Then sign- or
    // zero-extend it to 32 bits. A word access returns the word untouched,
    // whatever its low address bits are.
    function automatic logic [31:0] extractLoad(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic        zext);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   return zext ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return zext ? {16'h0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Build the word to store. A sub-word store takes the old word and
    // overwrites just its addressed lane(s). A word store replaces the
    // whole word.
    function automatic logic [31:0] mergeStore(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size);
        logic [31:0] merged;
        merged = old;
        case (size)
            2'b00: merged[{lane, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
        return merged;
    endfunction

    // A misaligned access can only be detected when the check is built in.
    // Without it, there is no misaligned path at all.
`ifdef MISALIGN_CHECK_EN
    assign misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                        (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // The unit is ready only when idle. It is also held not-ready for as
    // long as reset is asserted, so that nothing is accepted while reset
    // is being released.
    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;

    // All memory-side and response outputs come from registered state.
    // The request inputs never reach the memory combinationally.
    assign bus.MemRead    = (state_q == READ);
    assign bus.MemWrite   = (state_q == WRITE);
    assign bus.Address    = {{(32-WORD_IDX_W){1'b0}}, addr_q[WORD_IDX_W+1:2]};
    assign bus.write_data = (state_q == WRITE)
                          ? mergeStore(oldWord_q, wdata_q, addr_q[1:0], size_q)
                          : 32'h0;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = respRdata_q;

    // Next-state and capture logic.
    //   Loads:            READ then RESP.
    //   Word stores:      straight to WRITE.
    //   Sub-word stores:  READ first, so the old word is available to
    //                     merge into.
    //   Misaligned (when checked): jump directly to RESP.
    // The response data is updated only on entry to RESP. This keeps it
    // stable until the next response.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        zext_d      = zext_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        oldWord_d   = oldWord_q;
        respRdata_d = respRdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    zext_d  = bus.req_unsigned;
                    addr_d  = bus.req_addr[WORD_IDX_W+1:0];
                    wdata_d = bus.req_wdata;
                    if (misaligned) begin
                        state_d     = RESP;
                        respRdata_d = 32'h0;
                    end else if (!bus.req_we) begin
                        state_d = READ;
                    end else if (bus.req_size[1]) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                oldWord_d = bus.Read_Data;
                if (we_q) begin
                    state_d = WRITE;
                end else begin
                    state_d     = RESP;
                    respRdata_d = extractLoad(bus.Read_Data, addr_q[1:0], size_q, zext_q);
                end
            end
            WRITE: begin
                state_d     = RESP;
                respRdata_d = 32'h0;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-request registers. Reset drops the FSM straight
    // back to IDLE. Because MemWrite is decoded from the state, an
    // in-flight write is cut off immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            zext_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            oldWord_q   <= 32'h0;
            respRdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            zext_q      <= zext_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            oldWord_q   <= oldWord_d;
            respRdata_q <= respRdata_d;
        end
    end

`ifdef MISALIGN_CHECK_EN
    logic err_q, err_d;

    // The error flag is refreshed on entry to RESP. Arriving from IDLE can
    // only mean a rejected misaligned access. Arriving from READ or WRITE
    // means the access really went to memory.
    assign err_d        = (state_d == RESP) ? (state_q == IDLE) : err_q;
    assign bus.resp_err = err_q;

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign bus.resp_err = 1'b0;
`endif

endmodule
